// File: rtl/seg_status_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_status_arb_pkg
// Description : Shared types and sizing helpers for the status arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_status_arb_pkg;

    // Why the display is allowed to move this cycle.
    typedef enum logic [1:0] {
        CR_NONE      = 2'd0,
        CR_LOST      = 2'd1,
        CR_ERROR     = 2'd2,
        CR_HOLD_DONE = 2'd3
    } commit_reason_e;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : seg_prio_enc
// Description : Lowest-set-bit encoder; o_idx = NUM_SRC when nothing is set.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_prio_enc #(
    parameter int NUM_SRC = 6,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_SRC-1:0] i_vec,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);

    always_comb begin
        o_idx   = IDX_W'(NUM_SRC);
        o_found = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_status_arb.sv
`default_nettype none
// ============================================================================
// Module      : seg_status_arb
// Description : Priority arbiter for the 7-segment status display with sticky
//               errors, minimum dwell time and optional error blink
//               (enabled by defining SEG_STATUS_BLINK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module seg_status_arb
    import seg_status_arb_pkg::*;
#(
    parameter int NUM_SRC      = 6,
    parameter int DIGITS       = 3,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLINK_CYCLES = 25_000_000,
    localparam int W  = 4 * DIGITS,
    localparam int SW = cnt_width(NUM_SRC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [NUM_SRC-1:0]   src_error,
    input  logic [NUM_SRC*W-1:0] src_digits,
    input  logic [W-1:0]         default_digits,
    input  logic                 err_clear,
    output logic [W-1:0]         seg_digits,
    output logic                 seg_blank,
    output logic [SW-1:0]        active_src,
    output logic [NUM_SRC-1:0]   sticky_err
);

    localparam int            c_HOLD_W  = cnt_width(HOLD_CYCLES);
    localparam logic [SW-1:0] c_DEFAULT = SW'(NUM_SRC);

    if (NUM_SRC < 1 || DIGITS < 1 || HOLD_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_params
        $error("seg_status_arb: parameter out of range");
    end

    logic [NUM_SRC-1:0]  r_sticky;
    logic [SW-1:0]       r_active;
    logic [W-1:0]        r_digits;
    logic [c_HOLD_W-1:0] r_hold;

    logic [SW-1:0]       w_s_idx;
    logic [SW-1:0]       w_v_idx;
    logic                w_s_found;
    logic                w_v_found;
    logic [SW-1:0]       w_cand;
    logic [SW-1:0]       w_next;
    logic [NUM_SRC:0]    w_qual_ext;
    logic [NUM_SRC:0]    w_sticky_ext;
    logic                w_commit;
    logic [W-1:0]        w_next_digits;
    commit_reason_e      w_reason;

    seg_prio_enc #(.NUM_SRC(NUM_SRC), .IDX_W(SW)) u_enc_sticky (
        .i_vec   (r_sticky),
        .o_idx   (w_s_idx),
        .o_found (w_s_found)
    );

    seg_prio_enc #(.NUM_SRC(NUM_SRC), .IDX_W(SW)) u_enc_valid (
        .i_vec   (src_valid),
        .o_idx   (w_v_idx),
        .o_found (w_v_found)
    );

    // Any sticky source outranks every merely-valid one.
    assign w_cand       = w_s_found ? w_s_idx : (w_v_found ? w_v_idx : c_DEFAULT);
    assign w_qual_ext   = {1'b1, r_sticky | src_valid};
    assign w_sticky_ext = {1'b0, r_sticky};

    always_comb begin
        w_reason = CR_NONE;
        if (w_cand != r_active) begin
            if (!w_qual_ext[r_active]) begin
                w_reason = CR_LOST;
            end else if (w_s_found) begin
                w_reason = CR_ERROR;
            end else if (r_hold == '0) begin
                w_reason = CR_HOLD_DONE;
            end
        end
    end

    assign w_commit = (w_reason != CR_NONE);
    assign w_next   = w_commit ? w_cand : r_active;

    always_comb begin
        w_next_digits = default_digits;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_next == SW'(i)) begin
                w_next_digits = src_digits[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= '0;
            r_active <= c_DEFAULT;
            r_digits <= '0;
            r_hold   <= '0;
        end else begin
            r_sticky <= (r_sticky & ~{NUM_SRC{err_clear}}) | src_error;
            r_active <= w_next;
            r_digits <= w_next_digits;
            if (w_commit) begin
                r_hold <= c_HOLD_W'(HOLD_CYCLES - 1);
            end else if (r_hold != '0) begin
                r_hold <= r_hold - 1'b1;
            end
        end
    end

`ifdef SEG_STATUS_BLINK_EN
    localparam int c_BLINK_W = cnt_width(BLINK_CYCLES);

    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_blank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blank     <= 1'b0;
        end else if (w_commit || !w_sticky_ext[r_active]) begin
            r_blink_cnt <= '0;
            r_blank     <= 1'b0;
        end else if (r_blink_cnt == c_BLINK_W'(BLINK_CYCLES - 1)) begin
            r_blink_cnt <= '0;
            r_blank     <= ~r_blank;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign seg_blank = r_blank;
`else
    assign seg_blank = 1'b0;
`endif

    assign seg_digits = r_digits;
    assign active_src = r_active;
    assign sticky_err = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_seg_status_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_status_arb
// Description : Scoreboard bench for seg_status_arb against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_status_arb;

    localparam int N     = 6;
    localparam int D     = 3;
    localparam int W     = 4 * D;
    localparam int SW    = 3;
    localparam int HOLD  = 8;
    localparam int BLINK = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     src_valid;
    logic [N-1:0]     src_error;
    logic [N*W-1:0]   src_digits;
    logic [W-1:0]     default_digits;
    logic             err_clear;
    logic [W-1:0]     seg_digits;
    logic             seg_blank;
    logic [SW-1:0]    active_src;
    logic [N-1:0]     sticky_err;

    seg_status_arb #(
        .NUM_SRC      (N),
        .DIGITS       (D),
        .HOLD_CYCLES  (HOLD),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .src_valid      (src_valid),
        .src_error      (src_error),
        .src_digits     (src_digits),
        .default_digits (default_digits),
        .err_clear      (err_clear),
        .seg_digits     (seg_digits),
        .seg_blank      (seg_blank),
        .active_src     (active_src),
        .sticky_err     (sticky_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  digits;
        logic          blank;
        logic [SW-1:0] act;
        logic [N-1:0]  sticky;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Model state: who is shown, which errors are latched, when the last
    // switch happened and how long the current error has been on screen.
    int   m_act;
    bit   m_sticky[N];
    int   m_edge;
    int   m_last_commit;
    int   m_err_edges;

    task automatic model_reset();
        m_act = N;
        for (int i = 0; i < N; i++) m_sticky[i] = 1'b0;
        m_edge        = 0;
        m_last_commit = -HOLD;
        m_err_edges   = 0;
    endtask

    task automatic model_step();
        exp_t e;
        int   cand;
        bit   cand_err;
        bit   cur_ok;
        bit   showing_err;
        bit   commit;
        cand     = N;
        cand_err = 1'b0;
        for (int i = 0; i < N; i++)
            if (m_sticky[i] && cand == N) begin
                cand     = i;
                cand_err = 1'b1;
            end
        if (cand == N)
            for (int i = 0; i < N; i++)
                if (src_valid[i] && cand == N) cand = i;
        if (m_act == N) begin
            cur_ok      = 1'b1;
            showing_err = 1'b0;
        end else begin
            cur_ok      = m_sticky[m_act] || src_valid[m_act];
            showing_err = m_sticky[m_act];
        end
        commit = (cand != m_act) &&
                 (!cur_ok || cand_err || (m_edge - m_last_commit) >= HOLD);
        if (commit) begin
            m_act         = cand;
            m_last_commit = m_edge;
        end
        if (commit || !showing_err) m_err_edges = 0;
        else                        m_err_edges++;
        e.digits = (m_act == N) ? default_digits : src_digits[m_act*W +: W];
`ifdef SEG_STATUS_BLINK_EN
        e.blank  = ((m_err_edges / BLINK) % 2) == 1;
`else
        e.blank  = 1'b0;
`endif
        e.act    = SW'(m_act);
        for (int i = 0; i < N; i++) begin
            if (src_error[i])   m_sticky[i] = 1'b1;
            else if (err_clear) m_sticky[i] = 1'b0;
            e.sticky[i] = m_sticky[i];
        end
        m_edge++;
        q.push_back(e);
    endtask

    task automatic cmp(input string what, input logic [31:0] got,
                       input logic [31:0] exp, inout bit bad);
        if (got !== exp) begin
            $display("FAIL %s (vector %0d, t=%0t): got %0h expected %0h",
                     what, n_vec, $time, got, exp);
            bad = 1'b1;
        end
    endtask

    task automatic check_reset(input string tag);
        bit bad;
        bad = 1'b0;
        n_vec++;
        cmp({tag, " seg_digits"}, 32'(seg_digits), 32'h0, bad);
        cmp({tag, " seg_blank"},  32'(seg_blank),  32'h0, bad);
        cmp({tag, " active_src"}, 32'(active_src), N,     bad);
        cmp({tag, " sticky_err"}, 32'(sticky_err), 32'h0, bad);
        if (bad) n_bad++;
    endtask

    // Monitor: every registered output is a display update.
    initial begin
        exp_t e;
        bit   bad;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e   = q.pop_front();
                bad = 1'b0;
                n_vec++;
                cmp("seg_digits", 32'(seg_digits), 32'(e.digits), bad);
                cmp("seg_blank",  32'(seg_blank),  32'(e.blank),  bad);
                cmp("active_src", 32'(active_src), 32'(e.act),    bad);
                cmp("sticky_err", 32'(sticky_err), 32'(e.sticky), bad);
                if (bad) n_bad++;
            end
        end
    end

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] er, input logic clr);
        src_valid = v;
        src_error = er;
        err_clear = clr;
        for (int i = 0; i < N; i++) src_digits[i*W +: W] = W'($urandom);
        model_step();
        @(negedge clk);
    endtask

    task automatic reset_mid();
        #2 rst = 1'b1;
        #1 check_reset("async_reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [N-1:0] v;
        logic [N-1:0] er;
        rst            = 1'b1;
        src_valid      = '0;
        src_error      = '0;
        src_digits     = '0;
        default_digits = 12'hABC;
        err_clear      = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset("reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Idle, then a dwell-limited switch from source 3 to source 1.
        cycle('0, '0, 1'b0);
        repeat (3)  cycle(6'b001000, '0, 1'b0);
        repeat (12) cycle(6'b001010, '0, 1'b0);
        // Current source disappears mid-dwell.
        repeat (2)  cycle('0, '0, 1'b0);
        repeat (10) cycle(6'b001000, '0, 1'b0);
        cycle('0, '0, 1'b0);
        // Error pulse preempts, blinks, then clear returns to source 0.
        repeat (10) cycle(6'b000001, '0, 1'b0);
        cycle(6'b000001, 6'b010000, 1'b0);
        repeat (14) cycle(6'b000001, '0, 1'b0);
        cycle(6'b000001, '0, 1'b1);
        repeat (4)  cycle(6'b000001, '0, 1'b0);
        // Set and clear together: set wins.
        cycle(6'b000001, 6'b000100, 1'b1);
        repeat (3)  cycle(6'b000001, '0, 1'b0);
        cycle(6'b000001, '0, 1'b1);
        repeat (3)  cycle(6'b000001, '0, 1'b0);
        // Reset while an error is blinking.
        cycle('0, 6'b100000, 1'b0);
        repeat (7) cycle('0, '0, 1'b0);
        reset_mid();
        cycle('0, '0, 1'b0);

        v = '0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(15, 0) == 0) v[i] = ~v[i];
                er[i] = ($urandom_range(199, 0) == 0);
            end
            default_digits = W'($urandom);
            cycle(v, er, $urandom_range(59, 0) == 0);
            if (n == 700) reset_mid();
        end

        if (q.size() != 0) begin
            $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
            n_bad++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
